// File: rtl/fetch_pingpong_buf_2p_if.sv
// Bundled write/read handshake signals of the ping-pong fetch buffer.
// master = producer/consumer side, slave = the buffer itself.
interface fetch_pingpong_buf_2p_if #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 16,
    parameter int NUM_BANKS = 2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_BANKS + 1);

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             wr_done;
    logic             wr_rdy;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic             rd_done;
    logic             rd_rdy;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [CW-1:0]    fill_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        input  wr_rdy, rd_rdy, rd_data, rd_valid, fill_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        output wr_rdy, rd_rdy, rd_data, rd_valid, fill_cnt
    );
endinterface

// File: rtl/fetch_pingpong_buf_2p.sv
// Multi-bank ping-pong two-port buffer between the fetch engine (writer)
// and the consuming pipeline stage (reader). Banks are owned by exactly one
// side at a time; commit hands a bank to the reader, release hands it back.
module fetch_pingpong_buf_2p #(
    parameter int WIDTH     = 128,
    parameter int DEPTH     = 16,
    parameter int NUM_BANKS = 2,
    parameter int OUT_REG   = 0
) (
    input  logic clk,
    input  logic rst,
    fetch_pingpong_buf_2p_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PW = BW + AW;
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(NUM_BANKS);

    logic [WIDTH-1:0] mem [NUM_BANKS*DEPTH];

    logic [BW-1:0] wr_bank_q, wr_bank_d;
    logic [BW-1:0] rd_bank_q, rd_bank_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_s1_valid_q, rd_s1_valid_d;
    logic [WIDTH-1:0] rd_s1_data_q;

    logic          wr_rdy, rd_rdy;
    logic          wr_fire, commit_fire, rd_fire, rel_fire;
    logic [PW-1:0] wr_phys, rd_phys;

    // Handshake qualification and bank/count next-state.
    always_comb begin
        wr_rdy      = (count_q != FULL_CNT);
        rd_rdy      = (count_q != '0);
        wr_fire     = bus.wr_en   & wr_rdy;
        commit_fire = bus.wr_done & wr_rdy;
        rd_fire     = bus.rd_en   & rd_rdy;
        rel_fire    = bus.rd_done & rd_rdy;
        wr_phys     = {wr_bank_q, bus.wr_addr};
        rd_phys     = {rd_bank_q, bus.rd_addr};

        wr_bank_d = wr_bank_q;
        if (commit_fire) begin
            wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + BW'(1);
        end
        rd_bank_d = rd_bank_q;
        if (rel_fire) begin
            rd_bank_d = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + BW'(1);
        end

        count_d = count_q;
        case ({commit_fire, rel_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        rd_s1_valid_d = rd_fire;
    end

    // Bank pointers, occupancy and first-stage read valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q     <= '0;
            rd_bank_q     <= '0;
            count_q       <= '0;
            rd_s1_valid_q <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            count_q       <= count_d;
            rd_s1_valid_q <= rd_s1_valid_d;
        end
    end

    // Write port; storage contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_phys] <= bus.wr_data;
        end
    end

    // Registered read port; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s1_data_q <= '0;
        end else if (rd_fire) begin
            rd_s1_data_q <= mem[rd_phys];
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            // Optional second stage adds one cycle of read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_s1_valid_q;
                    if (rd_s1_valid_q) begin
                        rd_data_q <= rd_s1_data_q;
                    end
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end else begin : g_no_out_reg
            assign bus.rd_data  = rd_s1_data_q;
            assign bus.rd_valid = rd_s1_valid_q;
        end
    endgenerate

    assign bus.wr_rdy   = wr_rdy;
    assign bus.rd_rdy   = rd_rdy;
    assign bus.fill_cnt = count_q;
endmodule

// File: doc/fetch_pingpong_buf_2p.md
# fetch_pingpong_buf_2p

Parametrised multi-bank two-port reference buffer for the fetch/deblocking path. It generalises the single 128x16 two-port fetch RAM into NUM_BANKS ping-pong banks, each DEPTH x WIDTH. A producer fills one bank while a consumer reads an earlier committed bank, with bank-level commit/release handshakes and an optional output register. It sits between the external-memory fetch engine (writer) and the consuming pipeline stage (reader).

## Interface
Parameters:
- WIDTH, 128, data word width in bits.
- DEPTH, 16, words per bank; power of two, >= 2; AW = clog2(DEPTH).
- NUM_BANKS, 2, number of banks; >= 1; need not be a power of two.
- OUT_REG, 0, 0 = 1-cycle read latency; 1 = extra output register, 2-cycle latency.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  write strobe into the current write bank.
- wr_addr  in  AW  word address within the write bank.
- wr_data  in  WIDTH  write data.
- wr_done  in  1  commit the current write bank to the reader.
- wr_rdy  out  1  a free bank is available (count < NUM_BANKS).
- rd_en  in  1  read strobe from the current read bank.
- rd_addr  in  AW  word address within the read bank.
- rd_done  in  1  release the current read bank back to the writer.
- rd_rdy  out  1  a committed bank is available (count > 0).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data holds the result of an accepted read.
- fill_cnt  out  clog2(NUM_BANKS+1)  number of committed, unreleased banks.

## Operation
- Storage: behavioural array of NUM_BANKS*DEPTH words with a synchronous read. The physical address is {bank, addr}. Contents are not reset.
- State: wr_bank, rd_bank (0..NUM_BANKS-1) and count (0..NUM_BANKS).
  - wr_rdy = (count != NUM_BANKS).
  - rd_rdy = (count != 0).
  - fill_cnt = count.
- Write: accepted when wr_en && wr_rdy; writes mem[wr_bank][wr_addr]. When wr_rdy is 0, wr_en is ignored and memory is unchanged.
- Commit: accepted when wr_done && wr_rdy. wr_bank advances with explicit wrap (NUM_BANKS-1 -> 0) and count increments. If wr_en and wr_done occur in the same cycle, the write lands in the bank being committed.
- Read: accepted when rd_en && rd_rdy; reads mem[rd_bank][rd_addr]. When rd_rdy is 0, rd_en is ignored: rd_valid stays 0 and rd_data holds its value.
- Release: accepted when rd_done && rd_rdy. rd_bank advances with wrap and count decrements. If rd_en and rd_done occur in the same cycle, the read is taken from the bank being released, and the data is still returned correctly.
- Commit and release in the same cycle: count is unchanged and both pointers advance.
- Reader and writer never address the same bank, because a bank is owned by exactly one side, so no read-during-write hazard exists. This holds for NUM_BANKS = 1 as well.
- Commit with no prior writes is legal; the bank holds stale data.

## Timing
- Reset values:
  - count = 0, wr_bank = 0, rd_bank = 0.
  - rd_data = 0, rd_valid = 0, fill_cnt = 0.
  - wr_rdy = 1, rd_rdy = 0.
- Reset mid-operation: all banks become free immediately (asynchronous), and any in-flight read's rd_valid is suppressed.
- wr_rdy, rd_rdy and fill_cnt are registered-state derived. A commit in cycle N raises rd_rdy in cycle N+1.
- Read latency:
  - OUT_REG = 0: rd_en accepted in cycle N gives rd_data and rd_valid = 1 in cycle N+1.
  - OUT_REG = 1: the same read gives rd_data and rd_valid = 1 in cycle N+2.
  - rd_valid is 1 for exactly one cycle per accepted read. Back-to-back reads give one result per cycle.
- The write is visible to a read issued in the cycle after commit.

## Test plan
- Basic fill/drain (WIDTH=128, DEPTH=16, NUM_BANKS=2, OUT_REG=0).
  - Stimulus: write words 0..15 with data = addr*0x11, pulse wr_done, then read 0..15.
  - Required: fill_cnt 0 -> 1, rd_rdy = 1 the cycle after commit, each rd_data = addr*0x11 one cycle after rd_en.
- Full ping-pong.
  - Stimulus: commit two banks with patterns A and B.
  - Required: wr_rdy = 0, fill_cnt = 2, and a further wr_en leaves memory unchanged. After rd_done, wr_rdy = 1 and reads return B.
- Simultaneous commit and release at fill_cnt = 1.
  - Required: fill_cnt stays 1, both pointers advance, and subsequent reads return the newly committed bank's data.
- Empty and illegal accesses.
  - Stimulus: rd_en and rd_done with rd_rdy = 0.
  - Required: rd_valid stays 0, fill_cnt stays 0, rd_bank stays 0.
- Wrap and latency (NUM_BANKS=3, OUT_REG=1).
  - Stimulus: run 7 commit/release rounds with a distinct pattern per round.
  - Required: correct data every round, rd_valid exactly 2 cycles after each rd_en, and pointers wrap 2 -> 0.
- Async reset at fill_cnt = 2 during a read burst.
  - Required: within the reset cycle, fill_cnt = 0, wr_rdy = 1, rd_rdy = 0 and rd_valid = 0, with no rd_valid pulse after reset release.
